// File: rtl/highscore_pkg.sv
// Shared types and sizing for the high-score controller and its table.
package highscore_pkg;

   localparam int HS_ENTRIES = 5;
   localparam int HS_IDX_W   = 3;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SHIFT,
      WRITE,
      DONE
   } hs_state_t;

endpackage

// File: rtl/highscore_if.sv
// Game-side request/response bundle plus the display read port of the high-score block.
interface highscore_if #(parameter int SCORE_W = 8);
   import highscore_pkg::*;

   logic                game_over;
   logic [SCORE_W-1:0]  curr_score;
   logic                clear;
   logic [HS_IDX_W-1:0] rd_idx;
   logic [SCORE_W-1:0]  rd_data;
   logic                busy;
   logic                done;
   logic [HS_IDX_W-1:0] rank;

   modport master (
      output game_over, curr_score, clear, rd_idx,
      input  rd_data, busy, done, rank
   );

   modport slave (
      input  game_over, curr_score, clear, rd_idx,
      output rd_data, busy, done, rank
   );

endinterface

// File: rtl/highscore_table.sv
// Five descending score registers with one shift/write port, a display read port and a compare tap.
module highscore_table
   import highscore_pkg::*;
#(
   parameter int SCORE_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                shift_en,
   input  logic [HS_IDX_W-1:0] shift_idx,
   input  logic                wr_en,
   input  logic [HS_IDX_W-1:0] wr_idx,
   input  logic [SCORE_W-1:0]  wr_data,
   input  logic [HS_IDX_W-1:0] rd_idx,
   output logic [SCORE_W-1:0]  rd_data,
   input  logic [HS_IDX_W-1:0] cmp_idx,
   output logic [SCORE_W-1:0]  cmp_data
);

   logic [SCORE_W-1:0] hi [1:HS_ENTRIES];

   // Slot 1 never shifts; slot i takes slot i-1 when selected
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= HS_ENTRIES; i++) hi[i] <= '0;
      end else if (clear) begin
         for (int i = 1; i <= HS_ENTRIES; i++) hi[i] <= '0;
      end else begin
         for (int i = 2; i <= HS_ENTRIES; i++) begin
            if (shift_en && shift_idx == HS_IDX_W'(i)) hi[i] <= hi[i-1];
         end
         for (int i = 1; i <= HS_ENTRIES; i++) begin
            if (wr_en && wr_idx == HS_IDX_W'(i)) hi[i] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data  = '0;
      cmp_data = '0;
      for (int i = 1; i <= HS_ENTRIES; i++) begin
         if (rd_idx == HS_IDX_W'(i))  rd_data  = hi[i];
         if (cmp_idx == HS_IDX_W'(i)) cmp_data = hi[i];
      end
   end

endmodule

// File: rtl/highscore_ctrl.sv
// Insertion sequencer: scans for the slot, ripples lower entries down, writes the score, reports rank.
module highscore_ctrl
   import highscore_pkg::*;
#(
   parameter int SCORE_W = 8
) (
   input  logic       clock,
   input  logic       reset,
   highscore_if.slave bus
);

   localparam logic [HS_IDX_W-1:0] LAST_IDX = HS_IDX_W'(HS_ENTRIES);

   hs_state_t           state, state_n;
   logic [SCORE_W-1:0]  score_q;
   logic [HS_IDX_W-1:0] k, j, pos, rank_q;
   logic [SCORE_W-1:0]  cmp_data;
   logic                placed;
   logic                shift_en, wr_en, tbl_clear, done_c;

   assign placed = score_q > cmp_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // A slot found at the last index needs no ripple, so SCAN jumps straight to WRITE
   always_comb begin
      state_n   = state;
      shift_en  = 1'b0;
      wr_en     = 1'b0;
      tbl_clear = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clear)          tbl_clear = 1'b1;
            else if (bus.game_over) state_n = SCAN;
         end
         SCAN: begin
            if (placed)             state_n = (k == LAST_IDX) ? WRITE : SHIFT;
            else if (k == LAST_IDX) state_n = DONE;
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (j == pos + 3'd1) state_n = WRITE;
         end
         WRITE: begin
            wr_en   = 1'b1;
            state_n = DONE;
         end
         DONE: begin
            done_c  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         score_q <= '0;
         k       <= '0;
         j       <= '0;
         pos     <= '0;
         rank_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clear) begin
                  rank_q <= '0;
               end else if (bus.game_over) begin
                  score_q <= bus.curr_score;
                  k       <= 3'd1;
               end
            end
            SCAN: begin
               if (placed) begin
                  pos <= k;
                  j   <= LAST_IDX;
               end else if (k == LAST_IDX) begin
                  pos <= '0;
               end else begin
                  k <= k + 3'd1;
               end
            end
            SHIFT:   j <= j - 3'd1;
            DONE:    rank_q <= pos;
            default: ;
         endcase
      end
   end

   highscore_table #(.SCORE_W(SCORE_W)) u_table (
      .clock     (clock),
      .reset     (reset),
      .clear     (tbl_clear),
      .shift_en  (shift_en),
      .shift_idx (j),
      .wr_en     (wr_en),
      .wr_idx    (pos),
      .wr_data   (score_q),
      .rd_idx    (bus.rd_idx),
      .rd_data   (bus.rd_data),
      .cmp_idx   (k),
      .cmp_data  (cmp_data)
   );

   assign bus.busy = (state != IDLE);
   assign bus.done = done_c;
   assign bus.rank = rank_q;

endmodule

// File: tb/tb_highscore_ctrl.sv
// Directed plus randomized inserts against a sorted-list model of the high-score table.
module tb_highscore_ctrl;

   localparam int SCORE_W = 8;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   highscore_if #(.SCORE_W(SCORE_W)) bus ();

   highscore_ctrl #(.SCORE_W(SCORE_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int model [5];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Best-first list: new score goes before the first strictly smaller entry, last one falls off
   function automatic int model_insert(input int s);
      for (int i = 0; i < 5; i++) begin
         if (s > model[i]) begin
            for (int m = 4; m > i; m--) model[m] = model[m-1];
            model[i] = s;
            return i + 1;
         end
      end
      return 0;
   endfunction

   function automatic void model_zero();
      for (int i = 0; i < 5; i++) model[i] = 0;
   endfunction

   task automatic check_table(input string tag);
      for (int idx = 0; idx < 8; idx++) begin
         bus.rd_idx = 3'(idx);
         #1;
         check($sformatf("%s_rd%0d", tag, idx), 32'(bus.rd_data),
               (idx >= 1 && idx <= 5) ? 32'(model[idx-1]) : 32'd0);
      end
   endtask

   task automatic watch_quiet(input string tag);
      int extra;
      extra = 0;
      repeat (9) begin
         @(negedge clock);
         if (bus.done || bus.busy) extra++;
      end
      check({tag, "_quiet"}, 32'(extra), 32'd0);
   endtask

   // mode 0 plain, 1 game_over(99) while busy, 2 clear while busy, 3 game_over(99) in DONE cycle
   task automatic apply_stimulus(input logic [7:0] score, input int mode);
      int exp_rank, exp_cycle, done_cyc;
      @(negedge clock);
      bus.curr_score = score;
      bus.game_over  = 1'b1;
      @(negedge clock);
      bus.game_over  = 1'b0;
      exp_rank  = model_insert(int'(score));
      exp_cycle = (exp_rank != 0) ? 7 : 6;
      check("busy_rise", 32'(bus.busy), 32'd1);
      done_cyc = 0;
      for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
         if (c > 1) @(negedge clock);
         bus.game_over = 1'b0;
         bus.clear     = 1'b0;
         if (bus.done) begin
            done_cyc = c;
            if (mode == 3) begin
               bus.game_over  = 1'b1;
               bus.curr_score = 8'd99;
            end
         end else if (c == 2 && mode == 1) begin
            bus.game_over  = 1'b1;
            bus.curr_score = 8'd99;
         end else if (c == 3 && mode == 2) begin
            bus.clear = 1'b1;
         end
      end
      check("done_cycle", 32'(done_cyc), 32'(exp_cycle));
      @(negedge clock);
      bus.game_over = 1'b0;
      bus.clear     = 1'b0;
      check("busy_fall", 32'(bus.busy), 32'd0);
      check("done_pulse", 32'(bus.done), 32'd0);
      check("rank", 32'(bus.rank), 32'(exp_rank));
      watch_quiet("after_insert");
   endtask

   task automatic clear_table();
      @(negedge clock);
      bus.clear = 1'b1;
      @(negedge clock);
      bus.clear = 1'b0;
      model_zero();
      check("clear_busy", 32'(bus.busy), 32'd0);
      check("clear_rank", 32'(bus.rank), 32'd0);
   endtask

   initial begin
      int list1 [6];
      list1 = '{50, 30, 40, 10, 20, 60};
      bus.game_over  = 1'b0;
      bus.clear      = 1'b0;
      bus.curr_score = '0;
      bus.rd_idx     = '0;
      reset          = 1'b1;
      model_zero();
      repeat (2) @(negedge clock);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_rank", 32'(bus.rank), 32'd0);
      reset = 1'b0;
      check_table("reset");

      apply_stimulus(8'd50, 0);
      check_table("first");

      clear_table();
      foreach (list1[i]) apply_stimulus(8'(list1[i]), 0);
      check_table("sorted");

      apply_stimulus(8'd40, 0);
      check_table("tie");
      apply_stimulus(8'd20, 0);
      check_table("unplaced");

      apply_stimulus(8'd45, 1);
      check_table("go_busy");
      apply_stimulus(8'd35, 2);
      check_table("clear_busy");
      apply_stimulus(8'd25, 3);
      check_table("go_done");

      @(negedge clock);
      bus.clear      = 1'b1;
      bus.game_over  = 1'b1;
      bus.curr_score = 8'd77;
      @(negedge clock);
      bus.clear     = 1'b0;
      bus.game_over = 1'b0;
      model_zero();
      check("clr_go_busy", 32'(bus.busy), 32'd0);
      check("clr_go_done", 32'(bus.done), 32'd0);
      watch_quiet("clr_go");
      check_table("clr_go");

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) clear_table();
         else apply_stimulus(8'($urandom_range(0, 60)), int'($urandom_range(0, 3)));
         if (n % 8 == 7) check_table("rand");
      end
      check_table("rand_end");

      clear_table();
      apply_stimulus(8'd60, 0);
      apply_stimulus(8'd50, 0);
      apply_stimulus(8'd40, 0);
      apply_stimulus(8'd30, 0);
      apply_stimulus(8'd20, 0);
      @(negedge clock);
      bus.curr_score = 8'd55;
      bus.game_over  = 1'b1;
      @(negedge clock);
      bus.game_over = 1'b0;
      repeat (3) @(negedge clock);
      check("mid_shift_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_busy_now", 32'(bus.busy), 32'd0);
      check("rst_done_now", 32'(bus.done), 32'd0);
      @(posedge clock);
      #1;
      check("rst_busy_next", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      model_zero();
      check_table("rst_mid");
      watch_quiet("rst_mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/highscore_ctrl.md
# highscore_ctrl

Sequential controller that owns the snake game's five-entry high-score table and inserts the final score of each game into it. The game FSM pulses `game_over` with the final score. The block then scans the table, ripples lower entries down one slot per cycle, writes the new score and reports the rank achieved. A combinational read port serves the VGA score-display logic, which reads only while `busy` is low.

## Interface
Parameters:
- `SCORE_W`, 8, score width in bits; all table entries and `curr_score` use this width.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears the table and returns the FSM to IDLE.
- `game_over`  in  1  insert request, one-cycle pulse; sampled only in IDLE.
- `curr_score`  in  SCORE_W  final score; captured on the cycle `game_over` is accepted.
- `clear`  in  1  wipe the table to zero; honoured only in IDLE.
- `rd_idx`  in  3  read slot, 1 = best, 5 = fifth.
- `rd_data`  out  SCORE_W  combinational `hi[rd_idx]`; returns 0 for `rd_idx` 0, 6 or 7.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when an insert completes.
- `rank`  out  3  slot taken by the last insert (1..5), or 0 if the score did not qualify; held until the next `done`.

## Operation
- Storage: `hi[1..5]`, SCORE_W bits each, kept in descending order (`hi[1]` is highest). All entries are 0 after reset.
- FSM states: IDLE, SCAN, SHIFT, WRITE, DONE.
- IDLE:
  - `clear` high: zero all five entries and set `rank` to 0.
  - `game_over` high with `clear` low: capture `curr_score` into `score_q`, set `k` = 1, go to SCAN.
  - `clear` and `game_over` both high: `clear` wins and the request is dropped.
- SCAN: compare one entry per cycle.
  - If `score_q > hi[k]` (strict): set `pos` = `k`, set `j` = 5, go to SHIFT.
  - Otherwise, if `k` = 5: set `pos` = 0 and go to DONE.
  - Otherwise increment `k`.
- SHIFT:
  - If `j > pos`: `hi[j] <= hi[j-1]`, then decrement `j`.
  - When `j == pos`: go to WRITE. This takes zero shift cycles when `pos` = 5.
  - Entry 5 is overwritten first, so the old fifth score is discarded.
- WRITE: `hi[pos] <= score_q`, go to DONE.
- DONE: assert `done` for this cycle, load `rank <= pos`, return to IDLE.
- Inputs ignored while `busy` is high:
  - `game_over` requests are dropped, not queued.
  - `clear` has no effect.
- Ties: an equal score ranks below the existing entry. A score of 0 never enters the table.
- All arithmetic is unsigned. `k`, `j` and `pos` are 3 bits wide. The comparison uses SCORE_W bits, with no overflow case.

## Timing
- Reset values:
  - State IDLE; `busy` 0, `done` 0, `rank` 0.
  - All `hi` entries 0, so `rd_data` reads 0.
  - `score_q`, `k`, `j` and `pos` are 0.
- Cycle numbering: cycle 0 is the edge on which `game_over` is accepted.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- Placed score: SCAN takes `pos` cycles, SHIFT takes 5 − `pos` cycles, WRITE takes 1. `done` is high in cycle 7 regardless of `pos`.
- Unplaced score: SCAN takes 5 cycles. `done` is high in cycle 6 with `rank` = 0.
- Earliest next acceptance: a `game_over` that is high in the DONE cycle is dropped. The next request is accepted in the IDLE cycle that follows.
- `rd_data` follows `rd_idx` and table contents with no register stage. During SHIFT it can show a duplicated entry; this is legal because readers gate on `busy`.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately.
  - The table is zeroed, including a partially shifted one.
  - No `done` is produced.

## Structure
- Package `highscore_pkg` holds:
  - State enum `hs_state_t` (IDLE, SCAN, SHIFT, WRITE, DONE).
  - `HS_ENTRIES` = 5.
  - `HS_IDX_W` = 3.
- Sub-module `highscore_table` holds the five registers and provides:
  - Ports: `clear`, `shift_en` + `shift_idx`, `wr_en` + `wr_idx` + `wr_data`, `rd_idx`/`rd_data`, plus a compare tap `cmp_idx`/`cmp_data`.
  - It has no sequencing logic; the controller FSM drives all of these ports.

## Test plan
- Reset, then insert 50 → `done` in cycle 7, `rank` 1; table reads 50,0,0,0,0.
- Insert 50, 30, 40, 10, 20, 60 in order → table reads 60,50,40,30,20; the last `rank` is 1, and 10 is discarded.
- Full table 60,50,40,30,20, insert 40 → `rank` 4, table 60,50,40,40,30. Then insert 20 → `done` in cycle 6, `rank` 0, table unchanged.
- `game_over` with `curr_score` 99 pulsed while `busy` → ignored: exactly one `done` is produced and 99 is absent from the table. `clear` pulsed while `busy` → no effect.
- `clear` and `game_over` high in the same IDLE cycle → table all zero, no `busy`, no `done`.
- Assert `reset` during the SHIFT of a rank-2 insert into a full table → next cycle state IDLE, all `rd_data` reads 0, no `done` pulse.
